// File: rtl/pattern_event_logger_pkg.sv
// Shared definitions for the pattern event logger: event codes and record layout.
// A FIFO record is packed as {code, time}, with the 2-bit code in the MSBs.
package pattern_log_pkg;

  localparam int unsigned EV_CODE_W = 2;

  typedef enum logic [EV_CODE_W-1:0] {
    EV_NONE = 2'b00,
    EV_Y1   = 2'b01,
    EV_Y2   = 2'b10,
    EV_BOTH = 2'b11
  } ev_code_e;

  function automatic ev_code_e hit_code(input logic y1, input logic y2);
    return ev_code_e'({y2, y1});
  endfunction

endpackage

// File: rtl/pattern_event_logger_fifo.sv
// Event FIFO with valid/ready head, occupancy level and drop reporting.
// When full, a push is still accepted if a pop happens in the same cycle.
module pattern_event_fifo #(
  parameter int unsigned W     = 18,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     ck,
  input  logic                     rs,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic                     valid,
  output logic [W-1:0]             head,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          empty, full, pop_en, push_en;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == FULL_CNT);
    pop_en  = pop & ~empty & ~clr;
    // On a full FIFO the pop frees the head slot, which is exactly the write slot.
    push_en = push & ~clr & (~full | pop_en);
    drop    = push & ~clr & full & ~pop_en;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_en) wr_d = wr_q + 1'b1;
      if (pop_en)  rd_d = rd_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge ck) begin
    if (push_en) mem_q[wr_q] <= din;
  end

  assign valid = ~empty;
  assign head  = empty ? '0 : mem_q[rd_q];
  assign level = cnt_q;

endmodule

// File: rtl/pattern_event_logger.sv
// Logs detector hits (y1="1011", y2="1100") as timestamped records in a FIFO,
// with saturating per-pattern hit counters and dropped-event accounting.
module pattern_event_logger
  import pattern_log_pkg::*;
#(
  parameter int unsigned TW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     ck,
  input  logic                     rs,
  input  logic                     y1,
  input  logic                     y2,
  input  logic                     clr,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [1:0]               ev_code,
  output logic [TW-1:0]            ev_time,
  output logic [CW-1:0]            cnt1,
  output logic [CW-1:0]            cnt2,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drops
);

  localparam int unsigned RW = EV_CODE_W + TW;

  logic [TW-1:0] ts_q, ts_d;
  logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [7:0]    drops_q, drops_d;
  logic          ovf_q, ovf_d;
  logic          hit, drop;
  ev_code_e      code;
  logic [RW-1:0] rec, head;

  always_comb begin
    code = hit_code(y1, y2);
    hit  = y1 | y2;
    rec  = {code, ts_q};
    ts_d    = clr ? '0 : ts_q + TW'(1);
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    drops_d = drops_q;
    ovf_d   = ovf_q;
    if (clr) begin
      cnt1_d  = '0;
      cnt2_d  = '0;
      drops_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (y1 && cnt1_q != '1) cnt1_d = cnt1_q + CW'(1);
      if (y2 && cnt2_q != '1) cnt2_d = cnt2_q + CW'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drops_q != '1) drops_d = drops_q + 8'd1;
      end
    end
  end

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      ts_q    <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      drops_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      drops_q <= drops_d;
      ovf_q   <= ovf_d;
    end
  end

  pattern_event_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck    (ck),
    .rs    (rs),
    .clr   (clr),
    .push  (hit),
    .din   (rec),
    .pop   (ev_ready),
    .valid (ev_valid),
    .head  (head),
    .drop  (drop),
    .level (level)
  );

  assign ev_code  = head[RW-1:TW];
  assign ev_time  = head[TW-1:0];
  assign cnt1     = cnt1_q;
  assign cnt2     = cnt2_q;
  assign drops    = drops_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pattern_event_logger.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based behavioural model.
module tb_pattern_event_logger;

  localparam int TW    = 8;
  localparam int CW    = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int TMOD  = 1 << TW;
  localparam int CMAX  = (1 << CW) - 1;

  logic          ck = 1'b0;
  logic          rs = 1'b1;
  logic          y1 = 1'b0, y2 = 1'b0, clr = 1'b0, ev_ready = 1'b0;
  logic          ev_valid, overflow;
  logic [1:0]    ev_code;
  logic [TW-1:0] ev_time;
  logic [CW-1:0] cnt1, cnt2;
  logic [LW-1:0] level;
  logic [7:0]    drops;

  int checks = 0;
  int errors = 0;

  pattern_event_logger #(
    .TW    (TW),
    .CW    (CW),
    .DEPTH (DEPTH)
  ) dut (
    .ck       (ck),
    .rs       (rs),
    .y1       (y1),
    .y2       (y2),
    .clr      (clr),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_time  (ev_time),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .level    (level),
    .overflow (overflow),
    .drops    (drops)
  );

  always #5 ck = ~ck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of {code,time} records plus plain integer counters.
  logic [TW+1:0] mq[$];
  int m_ts, m_c1, m_c2, m_drops, m_ovf;

  always @(posedge ck or posedge rs) begin
    bit pop, push;
    if (rs || clr) begin
      mq.delete();
      m_ts = 0; m_c1 = 0; m_c2 = 0; m_drops = 0; m_ovf = 0;
    end else begin
      pop  = ev_ready && mq.size() > 0;
      push = y1 || y2;
      if (push && mq.size() == DEPTH && !pop) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back({y2, y1, TW'(m_ts)});
      end
      m_ts = (m_ts + 1) % TMOD;
      if (y1 && m_c1 < CMAX) m_c1++;
      if (y2 && m_c2 < CMAX) m_c2++;
    end
  end

  always @(negedge ck) begin
    chk("m_valid", 32'(ev_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_code", 32'(ev_code), 32'(mq[0][TW+1:TW]));
      chk("m_time", 32'(ev_time), 32'(mq[0][TW-1:0]));
    end
    chk("m_cnt1", 32'(cnt1), m_c1);
    chk("m_cnt2", 32'(cnt2), m_c2);
    chk("m_level", 32'(level), mq.size());
    chk("m_overflow", 32'(overflow), m_ovf);
    chk("m_drops", 32'(drops), m_drops);
  end

  task automatic drive(input logic a, input logic b, input logic r, input logic c);
    y1 = a; y2 = b; ev_ready = r; clr = c;
    @(posedge ck);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge ck);
    #2 rs = 1'b0;
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_code", 32'(ev_code), 0);
    chk("rst_time", 32'(ev_time), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_drops", 32'(drops), 0);

    // single y1 hit sampled at timestamp 5
    repeat (5) drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("first_valid", 32'(ev_valid), 1);
    chk("first_code", 32'(ev_code), 1);
    chk("first_time", 32'(ev_time), 5);
    chk("first_cnt1", 32'(cnt1), 1);
    chk("first_level", 32'(level), 1);

    drive(1, 1, 0, 0);
    chk("both_level", 32'(level), 2);
    chk("both_cnt1", 32'(cnt1), 2);
    chk("both_cnt2", 32'(cnt2), 1);
    chk("both_head_held", 32'(ev_time), 5);

    // fill past depth with y2 hits at timestamps 0..9
    drive(0, 0, 0, 1);
    chk("clr_level", 32'(level), 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);
    chk("full_level", 32'(level), 8);
    chk("full_drops", 32'(drops), 2);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_cnt2", 32'(cnt2), 10);
    chk("full_head", 32'(ev_time), 0);

    // full with simultaneous pop and push at timestamp 10
    drive(1, 0, 1, 0);
    chk("fpp_level", 32'(level), 8);
    chk("fpp_drops", 32'(drops), 2);
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 32'(ev_valid), 1);
      chk("drain_time", 32'(ev_time), (k < 7) ? k + 1 : 10);
      chk("drain_code", 32'(ev_code), (k < 7) ? 2 : 1);
      drive(0, 0, 1, 0);
    end
    chk("drained_valid", 32'(ev_valid), 0);
    chk("drained_level", 32'(level), 0);
    chk("drained_ovf", 32'(overflow), 1);

    // back-to-back hits with the host always ready
    drive(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 0);
      chk("b2b_valid", 32'(ev_valid), 1);
      chk("b2b_level", 32'(level), 1);
      chk("b2b_time", 32'(ev_time), i);
    end

    // asynchronous reset mid-cycle with entries queued
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
    chk("pre_arst_level", 32'(level), 3);
    rs = 1'b1;
    #1;
    chk("arst_valid", 32'(ev_valid), 0);
    chk("arst_code", 32'(ev_code), 0);
    chk("arst_time", 32'(ev_time), 0);
    chk("arst_cnt2", 32'(cnt2), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_drops", 32'(drops), 0);
    @(posedge ck);
    #2 rs = 1'b0;
    drive(1, 0, 0, 1);
    chk("clrhit_valid", 32'(ev_valid), 0);
    chk("clrhit_level", 32'(level), 0);
    chk("clrhit_cnt1", 32'(cnt1), 0);
    chk("clrhit_drops", 32'(drops), 0);

    // random traffic alternating between eager and stalled host phases
    for (int i = 0; i < 4000; i++) begin
      logic r;
      if (((i / 500) % 2) == 0) r = ($urandom % 4) != 0;
      else                      r = ($urandom % 16) == 0;
      drive(($urandom % 3) == 0, ($urandom % 3) == 0, r, ($urandom % 900) == 0);
    end
    drive(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_event_logger.md
Name: pattern_event_logger

Overview:
- Downstream consumer of the serial pattern detector's two hit outputs: y1 flags "1011", y2 flags "1100".
- Keeps saturating hit counters per pattern and a free-running cycle timestamp.
- Queues each hit as a {code, timestamp} record in a small FIFO, which a host drains over a valid/ready interface.
- Sits between the detector and the status/readout logic.

Parameters:
- TW, 16, timestamp counter width (bits).
- CW, 16, per-pattern hit counter width (bits).
- DEPTH, 8, event FIFO depth in entries; power of 2, minimum 2.

Ports:
- ck  in  1  clock; all state updates on the rising edge.
- rs  in  1  reset; asynchronous, active-high.
- y1  in  1  detector hit for pattern 1011; sampled each rising edge of ck.
- y2  in  1  detector hit for pattern 1100; sampled each rising edge of ck.
- clr  in  1  synchronous clear of all logger state; behaves like reset.
- ev_valid  out  1  FIFO head entry is available.
- ev_ready  in  1  host accepts the head entry.
- ev_code  out  2  head entry code: 01=y1, 10=y2, 11=both.
- ev_time  out  TW  head entry timestamp.
- cnt1  out  CW  saturating count of y1 hits.
- cnt2  out  CW  saturating count of y2 hits.
- level  out  clog2(DEPTH)+1  current number of FIFO entries.
- overflow  out  1  sticky flag: at least one event was dropped.
- drops  out  8  saturating count of dropped events.

Behaviour:
- Reset (rs=1, asynchronous) clears all of the following:
  - timestamp, cnt1, cnt2, drops, overflow and level go to 0.
  - ev_valid=0; ev_code=0 and ev_time=0.
- clr=1 at a rising edge has the same effect synchronously.
  - clr has priority over all hits and pops in that cycle.
  - A hit sampled in a clr cycle is discarded and not counted as a drop.
- Timestamp:
  - Increments by 1 every cycle and wraps from 2^TW-1 to 0.
  - No flag is raised on wrap.
- Hit sampling:
  - Every cycle with y1|y2 high is one event. There is no edge detection, so a hit held for 2 cycles gives 2 events.
  - ev_code = {y2, y1}.
  - The recorded time is the timestamp value before that edge's increment.
- Counters:
  - cnt1 increments on y1=1 and cnt2 on y2=1; both increment if both are high.
  - Each holds at 2^CW-1 once reached.
  - Counters update regardless of FIFO state.
- FIFO push:
  - An event is written at the sampling edge.
  - It is visible at the head (ev_valid=1) after that edge when the FIFO was empty, giving 1-cycle latency.
- FIFO pop:
  - Occurs on any edge with ev_valid & ev_ready.
  - The head advances, and the next entry or empty is presented after the edge.
  - ev_code/ev_time hold stable while ev_valid=1 and ev_ready=0.
- Full FIFO:
  - An event with no simultaneous pop is dropped: overflow is set to 1 and drops increments, saturating at 255.
  - Full with a simultaneous pop: the pop and the push both occur, level stays DEPTH, and nothing is dropped.
- Empty FIFO:
  - ev_ready has no effect.
  - A push in the same cycle simply fills the FIFO.
- level: push-only +1, pop-only -1, both or neither unchanged.
- overflow clears only on rs or clr.
- Read and write pointers are clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package pattern_log_pkg holds:
  - code constants EV_Y1=2'b01, EV_Y2=2'b10, EV_BOTH=2'b11;
  - the record field order {code, time}.
- One sub-module, pattern_event_fifo:
  - Parameterised width (2+TW) and DEPTH.
  - Carries the push/pop/full/empty/level logic and the simultaneous full push/pop rule.
- The top level holds the timestamp, the hit counters, drop accounting and clr.

Test Plan:
- Reset, then y1=1 for a single cycle sampled at timestamp 5 with ev_ready=0 -> ev_valid=1 next cycle, ev_code=01, ev_time=5, cnt1=1, level=1.
- y1 and y2 high in the same cycle -> one entry with ev_code=11; cnt1 and cnt2 each +1; level +1.
- DEPTH=8: 10 y2 hits with ev_ready=0 -> level=8, drops=2, overflow=1, cnt2=10. Then drain 8 entries -> timestamps are the first 8 hit times, in order.
- Full FIFO, ev_ready=1 and y1=1 in the same cycle -> level stays 8, drops unchanged, and the new entry appears last in the drain.
- Back-to-back hits every cycle with ev_ready=1 -> ev_valid stays high, level stays at 1, and ev_time values increase by 1 per entry.
- Assert rs asynchronously mid-cycle with 3 entries queued -> all outputs are 0 immediately, before the next edge. Then assert clr with y1=1 -> no entry is pushed and drops=0.
